// File: rtl/soc_system_vol_ramp_ctrl_if.sv
// soc_system_vol_ramp_ctrl_if: Avalon-MM slave bus of the volume ramp controller
interface soc_system_vol_ramp_ctrl_if;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/soc_system_vol_ramp_ctrl.sv
// soc_system_vol_ramp_ctrl: per-channel volume targets with tick-paced ramping, mute, bypass and done irq
module soc_system_vol_ramp_ctrl #(
    parameter int NUM_CH    = 2,
    parameter int WIDTH     = 7,
    parameter int RESET_VAL = 121,
    parameter int STEP      = 1,
    parameter int RATE_RST  = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    soc_system_vol_ramp_ctrl_if.slave bus,
    output logic                      irq,
    output logic [NUM_CH*WIDTH-1:0]   out_port
);
    // A step at least as large as the full range always lands on the target
    localparam int STEP_SAT = (STEP >= 2**WIDTH) ? 2**WIDTH - 1 : STEP;
    localparam logic [WIDTH:0] STEP_C = STEP_SAT[WIDTH:0];
    logic [WIDTH-1:0] r_tgt [NUM_CH];
    logic [WIDTH-1:0] r_cur [NUM_CH];
    logic [WIDTH-1:0] w_eff [NUM_CH];
    logic [WIDTH-1:0] w_nxt [NUM_CH];
    logic [7:0]       w_busy;
    logic [15:0]      r_rate, r_cnt;
    logic             r_mute, r_bypass, r_irq_en, r_done, r_busy_q;
    logic             w_wr, w_tick, w_any, w_set, w_clr, w_unused;

    function automatic logic [WIDTH-1:0] step_to(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] e);
        logic [WIDTH:0] d;
        d = (e > c) ? {1'b0, e} - {1'b0, c} : {1'b0, c} - {1'b0, e};
        if (d <= STEP_C) return e;
        return (e > c) ? c + STEP_C[WIDTH-1:0] : c - STEP_C[WIDTH-1:0];
    endfunction

    assign w_wr     = bus.chipselect && !bus.write_n;
    assign w_tick   = r_cnt >= r_rate;
    assign w_any    = |w_busy;
    assign w_set    = r_busy_q && !w_any;
    assign w_clr    = w_wr && bus.address == 4'd1 && bus.writedata[8];
    assign irq      = r_done && r_irq_en;
    assign w_unused = &{1'b0, bus.writedata[31:16]};

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_eff[i]  = r_mute ? '0 : r_tgt[i];
            w_busy[i] = r_cur[i] != w_eff[i];
            w_nxt[i]  = step_to(r_cur[i], w_eff[i]);
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            4'd0: bus.readdata = {29'b0, r_irq_en, r_bypass, r_mute};
            4'd1: bus.readdata = {23'b0, r_done, w_busy};
            4'd2: bus.readdata = {16'b0, r_rate};
            default: begin
                for (int i = 0; i < NUM_CH; i++)
                    if (bus.address == 4'(4 + i))
                        bus.readdata = {8'b0, 8'(r_cur[i]), 8'b0, 8'(r_tgt[i])};
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mute   <= 1'b0;
            r_bypass <= 1'b0;
            r_irq_en <= 1'b0;
            r_rate   <= 16'(RATE_RST);
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_busy_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_tgt[i] <= WIDTH'(RESET_VAL);
                r_cur[i] <= WIDTH'(RESET_VAL);
            end
        end else begin
            r_busy_q <= w_any;
            r_done   <= w_set || (r_done && !w_clr);
            r_cnt    <= ((w_wr && bus.address == 4'd2) || w_tick) ? '0 : r_cnt + 16'd1;
            if (w_wr && bus.address == 4'd0) {r_irq_en, r_bypass, r_mute} <= bus.writedata[2:0];
            if (w_wr && bus.address == 4'd2) r_rate <= bus.writedata[15:0];
            // Current levels always use pre-write target/CTRL; writes land next cycle
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr && bus.address == 4'(4 + i)) r_tgt[i] <= bus.writedata[WIDTH-1:0];
                r_cur[i] <= r_bypass ? w_eff[i] : w_tick ? w_nxt[i] : r_cur[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign out_port[g*WIDTH +: WIDTH] = r_cur[g];
    end
endmodule

// File: tb/tb_soc_system_vol_ramp_ctrl.sv
// tb_soc_system_vol_ramp_ctrl: directed register vectors plus ramp, bypass, edge and irq sequences
module tb_soc_system_vol_ramp_ctrl;
    localparam logic [13:0] OUT_RST = {7'd121, 7'd121};
    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic        irq0, irq4;
    logic [13:0] out0, out4;
    logic [31:0] d;
    int          tests = 0;
    int          fails = 0;
    int          e;
    vec_t        v [17];

    soc_system_vol_ramp_ctrl_if b0 ();
    soc_system_vol_ramp_ctrl_if b4 ();
    assign b0.address = address;
    assign b0.chipselect = chipselect;
    assign b0.write_n = write_n;
    assign b0.writedata = writedata;
    assign b4.address = address;
    assign b4.chipselect = chipselect;
    assign b4.write_n = write_n;
    assign b4.writedata = writedata;

    soc_system_vol_ramp_ctrl dut0 (.clk(clk), .reset(reset), .bus(b0.slave), .irq(irq0), .out_port(out0));
    soc_system_vol_ramp_ctrl #(.STEP(4)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave), .irq(irq4), .out_port(out4));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] dat);
        address = a;
        writedata = dat;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] dat);
        address = a;
        #1;
        dat = b0.readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        v = '{
            '{1'b0, 4'd0,  32'h0,        32'h0},
            '{1'b0, 4'd1,  32'h0,        32'h0},
            '{1'b0, 4'd2,  32'h0,        32'h400},
            '{1'b0, 4'd3,  32'h0,        32'h0},
            '{1'b0, 4'd4,  32'h0,        32'h00790079},
            '{1'b0, 4'd5,  32'h0,        32'h00790079},
            '{1'b0, 4'd6,  32'h0,        32'h0},
            '{1'b0, 4'd12, 32'h0,        32'h0},
            '{1'b0, 4'd15, 32'h0,        32'h0},
            '{1'b1, 4'd0,  32'hFFFFFFFC, 32'h4},
            '{1'b1, 4'd0,  32'h0,        32'h0},
            '{1'b1, 4'd2,  32'h00012345, 32'h2345},
            '{1'b1, 4'd4,  32'hFFFFFF79, 32'h00790079},
            '{1'b1, 4'd9,  32'h55,       32'h0},
            '{1'b1, 4'd3,  32'hFF,       32'h0},
            '{1'b1, 4'd1,  32'hFF,       32'h0},
            '{1'b0, 4'd2,  32'h0,        32'h2345}
        };
        idle(2);
        reset = 1'b0;
        chk("rst_out_port", out0, OUT_RST);
        chk("rst_irq", irq0, 0);
        foreach (v[i]) begin
            if (v[i].wr) wr(v[i].addr, v[i].wdata);
            rd(v[i].addr, d);
            chk($sformatf("vec%0d", i), d, v[i].exp);
            @(negedge clk);
        end
        chk("vec_out_port", out0, OUT_RST);

        // Reset asserted mid-ramp takes effect without a clock edge
        do_reset;
        wr(2, 0);
        wr(4, 0);
        idle(3);
        chk("pre_rst_ch0", out0[6:0], 118);
        #2 reset = 1'b1;
        #1 chk("async_rst_out", out0, OUT_RST);
        chk("async_rst_irq", irq0, 0);
        rd(2, d);
        chk("async_rst_rate", d, 1024);
        rd(1, d);
        chk("async_rst_status", d, 0);
        @(negedge clk);
        reset = 1'b0;

        // Ramp up by one every 4 clocks
        wr(2, 3);
        wr(4, 125);
        for (int j = 1; j <= 16; j++) begin
            idle(1);
            e = 121 + (j + 1) / 4;
            chk($sformatf("ramp_up_%0d", j), out0[6:0], (e > 125) ? 125 : e);
            if (j == 8) begin
                rd(1, d);
                chk("ramp_up_busy", d, 32'h1);
            end
        end
        rd(1, d);
        chk("ramp_up_done", d, 32'h100);
        chk("ramp_up_irq_off", irq0, 0);
        wr(0, 4);
        chk("irq_en_on", irq0, 1);
        wr(1, 32'h100);
        chk("irq_cleared", irq0, 0);

        // STEP = 4: no overshoot, mute down to 0, unmute back up
        do_reset;
        wr(2, 0);
        wr(4, 119);
        chk("s4_before", out4[6:0], 121);
        idle(1);
        chk("s4_one_tick", out4[6:0], 119);
        idle(2);
        chk("s4_hold", out4[6:0], 119);
        wr(0, 1);
        chk("s4_mute_wr", out4[6:0], 119);
        e = 119;
        for (int j = 1; j <= 32; j++) begin
            idle(1);
            e = (e <= 4) ? 0 : e - 4;
            chk($sformatf("s4_mute_%0d", j), out4[6:0], e);
        end
        wr(0, 0);
        chk("s4_unmute_wr", out4[6:0], 0);
        for (int j = 1; j <= 32; j++) begin
            idle(1);
            e = (119 - e <= 4) ? 119 : e + 4;
            chk($sformatf("s4_unmute_%0d", j), out4[6:0], e);
        end

        // Bypass follows target one cycle after the write
        do_reset;
        wr(0, 2);
        wr(5, 10);
        chk("byp_wr_cycle", out0[13:7], 121);
        idle(1);
        chk("byp_ch1", out0[13:7], 10);
        wr(0, 3);
        chk("byp_mute_wr", out0, {7'd10, 7'd121});
        idle(1);
        chk("byp_mute", out0, 0);

        // Target write on a tick cycle steps toward the old target
        do_reset;
        wr(2, 3);
        wr(4, 125);
        idle(6);
        chk("tickwr_pre", out0[6:0], 122);
        wr(4, 0);
        chk("tickwr_old_tgt", out0[6:0], 123);
        idle(3);
        chk("tickwr_hold", out0[6:0], 123);
        idle(1);
        chk("tickwr_redirect", out0[6:0], 122);

        // Ramp to full scale without wrapping
        do_reset;
        wr(2, 0);
        wr(4, 127);
        idle(12);
        chk("max_s1", out0[6:0], 127);
        chk("max_s4", out4[6:0], 127);
        chk("max_ch1", out0[13:7], 121);
        rd(4, d);
        chk("max_rd", d, 32'h007F007F);
        idle(5);
        chk("max_hold", out0[6:0], 127);

        // irq at ramp end; set outranks a simultaneous clear
        do_reset;
        wr(0, 4);
        wr(2, 0);
        wr(4, 123);
        chk("irq_t0", irq0, 0);
        idle(1);
        chk("irq_t1", irq0, 0);
        idle(1);
        chk("irq_t2", irq0, 0);
        idle(1);
        chk("irq_rise", irq0, 1);
        wr(4, 124);
        chk("irq_hold", irq0, 1);
        wr(1, 32'h100);
        chk("irq_clr", irq0, 0);
        rd(1, d);
        chk("irq_clr_status", d, 0);
        wr(1, 32'h100);
        chk("irq_set_wins", irq0, 1);
        rd(1, d);
        chk("irq_set_status", d, 32'h100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
